// File: rtl/fp32_pkg.sv
// Shared binary32 field layout, constant words and the unpacked-operand payload.
package fp32_pkg;

    localparam int unsigned FP_EXP_W = 8;
    localparam int unsigned FP_MAN_W = 23;
    localparam int unsigned FP_SIG_W = FP_MAN_W + 1;

    localparam int unsigned SIGN_BIT = 31;
    localparam int unsigned EXP_MSB  = 30;
    localparam int unsigned EXP_LSB  = 23;
    localparam int unsigned MAN_MSB  = 22;
    localparam int unsigned MAN_LSB  = 0;

    localparam logic [31:0]         QNAN     = 32'h7FC0_0000;
    localparam logic [31:0]         POS_INF  = 32'h7F80_0000;
    localparam logic [FP_EXP_W-1:0] EXP_ALL1 = 8'hFF;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exponent;
        logic [FP_SIG_W-1:0] sig;
        logic                is_nan;
        logic                is_inf;
        logic                is_zero;
    } fp_unpacked_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational split of a binary32 word into sign, effective exponent, significand and class flags.
module fp_unpack
    import fp32_pkg::*;
(
    input  logic [31:0]  word,
    input  logic         flip_sign,
    output fp_unpacked_t op
);

    logic [FP_EXP_W-1:0] exp_raw;
    logic [FP_MAN_W-1:0] man;

    // Field split; denormals get the hidden bit cleared and exponent forced to 1.
    always_comb begin
        exp_raw     = word[EXP_MSB:EXP_LSB];
        man         = word[MAN_MSB:MAN_LSB];
        op          = '0;
        op.sign     = word[SIGN_BIT] ^ flip_sign;
        op.exponent = (exp_raw == '0) ? FP_EXP_W'(1) : exp_raw;
        op.sig      = {(exp_raw != '0), man};
        op.is_nan   = (exp_raw == EXP_ALL1) && (man != '0);
        op.is_inf   = (exp_raw == EXP_ALL1) && (man == '0);
        op.is_zero  = (exp_raw == '0) && (man == '0);
    end

endmodule

// File: rtl/fp_align_addsub.sv
// Two-stage FP add/sub front end: unpack and order by magnitude, then align and add/subtract.
module fp_align_addsub
    import fp32_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_a,
    input  logic [31:0]        in_b,
    input  logic               in_op_sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAN_W+1:0]   out_significand,
    output logic [EXP_W-1:0]   out_exponent,
    output logic               out_sign,
    output logic               out_eff_sub,
    output logic               out_sticky,
    output logic               out_special,
    output logic [31:0]        out_special_val
);

    localparam int unsigned SIG_W = MAN_W + 1;

    fp_unpacked_t ua;
    fp_unpacked_t ub;

    logic             s2_load;
    logic             in_fire;
    logic             a_ge_b;
    logic             eff_sub;
    logic [SIG_W-1:0] sig_l;
    logic [SIG_W-1:0] sig_s;
    logic [EXP_W-1:0] exp_l;
    logic [EXP_W-1:0] diff;
    logic             sign_l;
    logic             special;
    logic [31:0]      special_val;

    logic             s1_valid;
    logic [SIG_W-1:0] s1_sig_l;
    logic [SIG_W-1:0] s1_sig_s;
    logic [EXP_W-1:0] s1_exp_l;
    logic [EXP_W-1:0] s1_diff;
    logic             s1_sign;
    logic             s1_eff_sub;
    logic             s1_special;
    logic [31:0]      s1_special_val;

    logic [2*SIG_W-1:0] ext;
    logic [SIG_W-1:0]   shifted;
    logic               sticky;
    logic [SIG_W:0]     sum;

    fp_unpack u_unpack_a (.word(in_a), .flip_sign(1'b0),      .op(ua));
    fp_unpack u_unpack_b (.word(in_b), .flip_sign(in_op_sub), .op(ub));

    // Handshake: a stage loads when empty or draining in the same cycle.
    always_comb begin
        s2_load  = !out_valid || out_ready;
        in_ready = !s1_valid || s2_load;
        in_fire  = in_valid && in_ready;
    end

    // S1: magnitude ordering (A wins ties) and special-result detection.
    always_comb begin
        a_ge_b      = in_a[SIGN_BIT-1:0] >= in_b[SIGN_BIT-1:0];
        eff_sub     = ua.sign ^ ub.sign;
        sig_l       = a_ge_b ? ua.sig : ub.sig;
        sig_s       = a_ge_b ? ub.sig : ua.sig;
        exp_l       = a_ge_b ? ua.exponent : ub.exponent;
        diff        = a_ge_b ? (ua.exponent - ub.exponent) : (ub.exponent - ua.exponent);
        sign_l      = a_ge_b ? ua.sign : ub.sign;
        special     = 1'b0;
        special_val = '0;
        if (ua.is_nan || ub.is_nan) begin
            special     = 1'b1;
            special_val = QNAN;
        end else if (ua.is_inf && ub.is_inf) begin
            special     = 1'b1;
            special_val = eff_sub ? QNAN : (POS_INF | {ua.sign, 31'b0});
        end else if (ua.is_inf) begin
            special     = 1'b1;
            special_val = POS_INF | {ua.sign, 31'b0};
        end else if (ub.is_inf) begin
            special     = 1'b1;
            special_val = POS_INF | {ub.sign, 31'b0};
        end else if (ua.is_zero && ub.is_zero) begin
            special     = 1'b1;
            special_val = {ua.sign & ub.sign, 31'b0};
        end else if (eff_sub && (in_a[SIGN_BIT-1:0] == in_b[SIGN_BIT-1:0])) begin
            special     = 1'b1;
            special_val = '0;
        end
    end

    // S1 register: valid tracks load/drain, data captured on input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid       <= 1'b0;
            s1_sig_l       <= '0;
            s1_sig_s       <= '0;
            s1_exp_l       <= '0;
            s1_diff        <= '0;
            s1_sign        <= 1'b0;
            s1_eff_sub     <= 1'b0;
            s1_special     <= 1'b0;
            s1_special_val <= '0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            if (in_fire) begin
                s1_sig_l       <= sig_l;
                s1_sig_s       <= sig_s;
                s1_exp_l       <= exp_l;
                s1_diff        <= diff;
                s1_sign        <= sign_l;
                s1_eff_sub     <= eff_sub;
                s1_special     <= special;
                s1_special_val <= special_val;
            end
        end
    end

    // S2: align the smaller significand (bits past the LSB fold into sticky) and add/subtract.
    always_comb begin
        ext     = {s1_sig_s, SIG_W'(0)} >> s1_diff;
        shifted = ext[2*SIG_W-1:SIG_W];
        sticky  = (s1_diff >= EXP_W'(SIG_W)) ? (|s1_sig_s) : (|ext[SIG_W-1:0]);
        if (s1_eff_sub) begin
            sum = {1'b0, s1_sig_l} + {1'b0, ~shifted} + (SIG_W+1)'(1);
        end else begin
            sum = {1'b0, s1_sig_l} + {1'b0, shifted};
        end
    end

    // S2 register: output payload, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            out_significand <= '0;
            out_exponent    <= '0;
            out_sign        <= 1'b0;
            out_eff_sub     <= 1'b0;
            out_sticky      <= 1'b0;
            out_special     <= 1'b0;
            out_special_val <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_significand <= s1_special ? '0 : sum;
                out_exponent    <= s1_special ? '0 : s1_exp_l;
                out_sticky      <= s1_special ? 1'b0 : sticky;
                out_sign        <= s1_sign;
                out_eff_sub     <= s1_eff_sub;
                out_special     <= s1_special;
                out_special_val <= s1_special_val;
            end
        end
    end

endmodule

// File: tb/tb_fp_align_addsub.sv
// Directed bench for fp_align_addsub: arithmetic vectors, specials, backpressure and reset.
module tb_fp_align_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] out_significand;
    logic [7:0]  out_exponent;
    logic        out_sign;
    logic        out_eff_sub;
    logic        out_sticky;
    logic        out_special;
    logic [31:0] out_special_val;

    int n_cmp = 0;
    int n_mis = 0;

    fp_align_addsub #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op_sub(in_op_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_significand(out_significand), .out_exponent(out_exponent),
        .out_sign(out_sign), .out_eff_sub(out_eff_sub), .out_sticky(out_sticky),
        .out_special(out_special), .out_special_val(out_special_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Called at posedge+1; offers one operand pair until accepted, returns at posedge+1.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub);
        bit done = 1'b0;
        in_a = a; in_b = b; in_op_sub = sub; in_valid = 1'b1;
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 32'(in_ready), 32'd1);
    endtask

    // Waits (bounded) for out_valid; returns at a negedge.
    task automatic wait_out(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic arith(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [24:0] sig, input logic [7:0] ex,
                         input logic sgn, input logic eff, input logic stk);
        send(a, b, sub);
        wait_out(tag);
        chk({tag, "_special"}, 32'(out_special), 32'd0);
        chk({tag, "_sig"}, 32'(out_significand), 32'(sig));
        chk({tag, "_exp"}, 32'(out_exponent), 32'(ex));
        chk({tag, "_sign"}, 32'(out_sign), 32'(sgn));
        chk({tag, "_effsub"}, 32'(out_eff_sub), 32'(eff));
        chk({tag, "_sticky"}, 32'(out_sticky), 32'(stk));
        @(posedge clk); #1;
    endtask

    task automatic spec(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] val);
        send(a, b, sub);
        wait_out(tag);
        chk({tag, "_special"}, 32'(out_special), 32'd1);
        chk({tag, "_val"}, out_special_val, val);
        chk({tag, "_sig0"}, 32'(out_significand), 32'd0);
        @(posedge clk); #1;
    endtask

    logic [31:0] bp_a [4];
    logic [31:0] bp_b [4];
    logic        bp_s [4];
    logic [24:0] bp_sig [4];
    int          idx_in;
    int          idx_out;
    bit          fire;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op_sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sig", 32'(out_significand), 32'd0);
        chk("rst_special_val", out_special_val, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: nothing visible one cycle after accept.
        send(32'h3F80_0000, 32'h3F80_0000, 1'b0);
        @(negedge clk);
        chk("latency_s1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("latency_s2", 32'(out_valid), 32'd1);
        chk("one_plus_one_sig", 32'(out_significand), 32'h0100_0000);
        @(posedge clk); #1;

        arith("add_1_1",    32'h3F80_0000, 32'h3F80_0000, 1'b0, 25'h100_0000, 8'h7F, 1'b0, 1'b0, 1'b0);
        arith("sub_15_1",   32'h3FC0_0000, 32'h3F80_0000, 1'b1, 25'h140_0000, 8'h7F, 1'b0, 1'b1, 1'b0);
        arith("sub_1_15",   32'h3F80_0000, 32'h3FC0_0000, 1'b1, 25'h140_0000, 8'h7F, 1'b1, 1'b1, 1'b0);
        arith("add_2p24_1", 32'h4B80_0000, 32'h3F80_0000, 1'b0, 25'h080_0000, 8'h97, 1'b0, 1'b0, 1'b1);
        arith("add_1_half", 32'h3F80_0000, 32'h3F00_0000, 1'b0, 25'h0C0_0000, 8'h7F, 1'b0, 1'b0, 1'b0);
        arith("add_1_d24",  32'h3F80_0000, 32'h3380_0000, 1'b0, 25'h080_0000, 8'h7F, 1'b0, 1'b0, 1'b1);
        arith("add_1_d23",  32'h3F80_0000, 32'h3440_0000, 1'b0, 25'h080_0001, 8'h7F, 1'b0, 1'b0, 1'b1);
        arith("add_1_den",  32'h3F80_0000, 32'h0000_0001, 1'b0, 25'h080_0000, 8'h7F, 1'b0, 1'b0, 1'b1);
        arith("add_den",    32'h0000_0003, 32'h0000_0001, 1'b0, 25'h000_0004, 8'h01, 1'b0, 1'b0, 1'b0);

        spec("nan_add",     32'h7FC0_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000);
        spec("inf_sub_inf", 32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000);
        spec("inf_add_inf", 32'h7F80_0000, 32'h7F80_0000, 1'b0, 32'h7F80_0000);
        spec("ninf_add_1",  32'hFF80_0000, 32'h3F80_0000, 1'b0, 32'hFF80_0000);
        spec("one_sub_inf", 32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000);
        spec("one_sub_one", 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000);
        spec("nz_add_nz",   32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000);
        spec("nz_sub_pz",   32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000);
        spec("pz_sub_pz",   32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000);

        // Backpressure: four back-to-back inputs with the consumer stalled for three cycles.
        bp_a[0] = 32'h3F80_0000; bp_b[0] = 32'h3F80_0000; bp_s[0] = 1'b0; bp_sig[0] = 25'h100_0000;
        bp_a[1] = 32'h3FC0_0000; bp_b[1] = 32'h3F80_0000; bp_s[1] = 1'b1; bp_sig[1] = 25'h140_0000;
        bp_a[2] = 32'h3F80_0000; bp_b[2] = 32'h3F00_0000; bp_s[2] = 1'b0; bp_sig[2] = 25'h0C0_0000;
        bp_a[3] = 32'h4B80_0000; bp_b[3] = 32'h3F80_0000; bp_s[3] = 1'b0; bp_sig[3] = 25'h080_0000;
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = bp_a[0]; in_b = bp_b[0]; in_op_sub = bp_s[0];
        @(negedge clk);
        chk("bp_ready_0", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_a = bp_a[1]; in_b = bp_b[1]; in_op_sub = bp_s[1];
        @(negedge clk);
        chk("bp_ready_1", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_a = bp_a[2]; in_b = bp_b[2]; in_op_sub = bp_s[2];
        @(negedge clk);
        chk("bp_ready_drop", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_a", 32'(out_significand), 32'(bp_sig[0]));
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_ready_still", 32'(in_ready), 32'd0);
        chk("bp_hold_b", 32'(out_significand), 32'(bp_sig[0]));
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_hold_c", 32'(out_significand), 32'(bp_sig[0]));
        out_ready = 1'b1;
        #1;
        chk("bp_full_pass", 32'(in_ready), 32'd1);
        idx_in = 2; idx_out = 0;
        for (int c = 0; c < 20 && idx_out < 4; c++) begin
            if (out_valid) begin
                chk($sformatf("bp_order_%0d", idx_out), 32'(out_significand), 32'(bp_sig[idx_out]));
                idx_out++;
            end
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) begin
                idx_in++;
                if (idx_in < 4) begin
                    in_a = bp_a[idx_in]; in_b = bp_b[idx_in]; in_op_sub = bp_s[idx_in];
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        chk("bp_count", 32'(idx_out), 32'd4);
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Reset with a full pipe: everything in flight is dropped.
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 32'h3F80_0000; in_b = 32'h3F80_0000; in_op_sub = 1'b0;
        @(posedge clk); #1;
        in_a = 32'h3FC0_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_full_valid", 32'(out_valid), 32'd1);
        chk("rst_full_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_sig", 32'(out_significand), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst_rel_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rst_no_out_%0d", i), 32'(out_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
